// File: rtl/pe_pkg.sv
// Shared types and helpers for the systolic processing element: FSM state,
// pipeline-depth limits and the signed saturation used when draining results.
package pe_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    FLUSH = 1'b1
  } pe_state_t;

  localparam int MULT_STAGES_MIN = 1;
  localparam int MULT_STAGES_MAX = 4;

  // Wide enough to hold MULT_STAGES_MAX as a down-counter load value.
  localparam int CNT_W = 3;

  // Saturation works in a fixed wide domain so one function serves every
  // ACC_W/RES_W pairing; callers sign-extend in and truncate the return value.
  localparam int SAT_MAX_W = 128;

  function automatic logic [SAT_MAX_W-1:0] sat_signed(
    input logic signed [SAT_MAX_W-1:0] value,
    input int                          res_w
  );
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    hi = $signed((SAT_MAX_W'(1) << (res_w - 1)) - SAT_MAX_W'(1));
    lo = ~hi;
    if (value > hi) begin
      sat_signed = hi;
    end else if (value < lo) begin
      sat_signed = lo;
    end else begin
      sat_signed = value;
    end
  endfunction

  function automatic logic sat_clamped(
    input logic signed [SAT_MAX_W-1:0] value,
    input int                          res_w
  );
    sat_clamped = (sat_signed(value, res_w) != value);
  endfunction

endpackage

// File: rtl/pe_mult_pipe.sv
// Signed multiplier followed by a valid-tagged register chain of MULT_STAGES
// stages; the product registers carry no enable so DSP pipeline regs can absorb them.
module pe_mult_pipe #(
  parameter int DATA_W      = 16,
  parameter int MULT_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  out_valid,
  output logic [2*DATA_W-1:0]   product
);

  localparam int P_W = 2 * DATA_W;

  logic signed [P_W-1:0] a_ext;
  logic signed [P_W-1:0] b_ext;
  logic signed [P_W-1:0] prod_comb;

  logic [P_W-1:0]         prod_q [MULT_STAGES];
  logic [MULT_STAGES-1:0] tag_q;

  // A DATA_W x DATA_W signed product always fits in 2*DATA_W bits.
  assign a_ext     = P_W'($signed(a));
  assign b_ext     = P_W'($signed(b));
  assign prod_comb = a_ext * b_ext;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MULT_STAGES; i++) begin
        prod_q[i] <= '0;
      end
    end else begin
      prod_q[0] <= prod_comb;
      for (int i = 1; i < MULT_STAGES; i++) begin
        prod_q[i] <= prod_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_q <= '0;
    end else if (clear) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= in_valid;
      for (int i = 1; i < MULT_STAGES; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign out_valid = tag_q[MULT_STAGES-1];
  assign product   = prod_q[MULT_STAGES-1];

endmodule

// File: rtl/systolic_pe.sv
// Systolic MAC processing element: forwards operands east/south, accumulates
// signed products and drains a saturated result into a per-column shift chain.
module systolic_pe
  import pe_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int RES_W       = 2 * DATA_W,
  parameter int ACC_W       = 2 * DATA_W + 8,
  parameter int MULT_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] weight_in,
  output logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] weight_out,
  output logic              out_valid,
  input  logic              drain,
  output logic              busy,
  output logic              err,
  input  logic              shift_en,
  input  logic [RES_W-1:0]  shift_in,
  input  logic              shift_in_valid,
  input  logic              shift_in_sat,
  output logic [RES_W-1:0]  result,
  output logic              res_valid,
  output logic              res_sat
);

  if (MULT_STAGES < MULT_STAGES_MIN || MULT_STAGES > MULT_STAGES_MAX) begin : g_bad_stages
    $error("systolic_pe: MULT_STAGES out of range");
  end
  if (ACC_W < RES_W) begin : g_bad_acc
    $error("systolic_pe: ACC_W must be at least RES_W");
  end

  pe_state_t             state_q;
  pe_state_t             state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [SAT_MAX_W-1:0] acc_ext;

  logic                  accept;
  logic                  capture;
  logic                  pipe_valid;
  logic [2*DATA_W-1:0]   pipe_product;
  logic [RES_W-1:0]      res_next;
  logic                  res_clamp;

  // Forwarding is free-running: neighbours see every input one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out   <= '0;
      weight_out <= '0;
      out_valid  <= 1'b0;
    end else begin
      data_out   <= data_in;
      weight_out <= weight_in;
      out_valid  <= in_valid;
    end
  end

  pe_mult_pipe #(
    .DATA_W      (DATA_W),
    .MULT_STAGES (MULT_STAGES)
  ) u_mult_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .in_valid  (accept),
    .a         (data_in),
    .b         (weight_in),
    .out_valid (pipe_valid),
    .product   (pipe_product)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ACCUM;
    end else if (clear) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (drain) state_d = FLUSH;
      FLUSH:   if (cnt_q == '0) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    busy    = (state_q == FLUSH);
    capture = (state_q == FLUSH) && (cnt_q == '0);
    accept  = in_valid && (state_q == ACCUM);
  end

  // Counts the in-flight products still to land before the capture cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (state_q == ACCUM && drain) begin
      cnt_q <= CNT_W'(MULT_STAGES);
    end else if (state_q == FLUSH && cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else if (clear || capture) begin
      acc_q <= '0;
    end else if (pipe_valid) begin
      acc_q <= acc_q + ACC_W'($signed(pipe_product));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err <= 1'b0;
    end else if (clear) begin
      err <= 1'b0;
    end else if (in_valid && state_q == FLUSH) begin
      err <= 1'b1;
    end
  end

  assign acc_ext   = SAT_MAX_W'(acc_q);
  assign res_next  = RES_W'(sat_signed(acc_ext, RES_W));
  assign res_clamp = sat_clamped(acc_ext, RES_W);

  // Result registers ignore clear so a drained tile survives a flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result    <= '0;
      res_valid <= 1'b0;
      res_sat   <= 1'b0;
    end else if (capture) begin
      result    <= res_next;
      res_valid <= 1'b1;
      res_sat   <= res_clamp;
    end else if (shift_en) begin
      result    <= shift_in;
      res_valid <= shift_in_valid;
      res_sat   <= shift_in_sat;
    end
  end

endmodule

// File: tb/tb_systolic_pe.sv
// Bench for two chained systolic_pe instances (index 0 upstream, 1 downstream)
// checked against an arithmetic tile-sum model with signed clamping.
module tb_systolic_pe;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic        shift_en = 1'b0;
  logic        in_valid [2];
  logic        drain [2];
  logic [7:0]  data_in [2];
  logic [7:0]  weight_in [2];
  logic [7:0]  data_out [2];
  logic [7:0]  weight_out [2];
  logic        out_valid [2];
  logic        busy [2];
  logic        err [2];
  logic [15:0] result [2];
  logic        res_valid [2];
  logic        res_sat [2];
  logic [15:0] up_shift_in = '0;
  logic        up_shift_valid = 1'b0;
  logic        up_shift_sat = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  bit fwd_on  = 1'b0;

  logic signed [7:0] ta [$];
  logic signed [7:0] tb [$];
  logic [15:0] last_res;
  logic        last_sat;

  systolic_pe #(.DATA_W(8), .RES_W(16), .ACC_W(24), .MULT_STAGES(2)) u_up (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid[0]),
    .data_in(data_in[0]), .weight_in(weight_in[0]), .data_out(data_out[0]),
    .weight_out(weight_out[0]), .out_valid(out_valid[0]), .drain(drain[0]),
    .busy(busy[0]), .err(err[0]), .shift_en(shift_en), .shift_in(up_shift_in),
    .shift_in_valid(up_shift_valid), .shift_in_sat(up_shift_sat),
    .result(result[0]), .res_valid(res_valid[0]), .res_sat(res_sat[0])
  );

  systolic_pe #(.DATA_W(8), .RES_W(16), .ACC_W(24), .MULT_STAGES(2)) u_dn (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid[1]),
    .data_in(data_in[1]), .weight_in(weight_in[1]), .data_out(data_out[1]),
    .weight_out(weight_out[1]), .out_valid(out_valid[1]), .drain(drain[1]),
    .busy(busy[1]), .err(err[1]), .shift_en(shift_en), .shift_in(result[0]),
    .shift_in_valid(res_valid[0]), .shift_in_sat(res_sat[0]),
    .result(result[1]), .res_valid(res_valid[1]), .res_sat(res_sat[1])
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] clamp16(input longint s);
    logic [63:0] v;
    v = s;
    if (s > 32767) return 16'h7fff;
    if (s < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  function automatic bit is_sat16(input longint s);
    return (s > 32767) || (s < -32768);
  endfunction

  // One clock: remember what was driven, then confirm it reappears on the
  // forwarding outputs after the edge.
  task automatic tick();
    logic [7:0] sd [2];
    logic [7:0] sw [2];
    logic       sv [2];
    bit         chk;
    chk = fwd_on && reset_n;
    for (int p = 0; p < 2; p++) begin
      sd[p] = data_in[p];
      sw[p] = weight_in[p];
      sv[p] = in_valid[p];
    end
    @(posedge clk);
    #1;
    if (chk) begin
      for (int p = 0; p < 2; p++) begin
        check("fwd_data", data_out[p], sd[p]);
        check("fwd_weight", weight_out[p], sw[p]);
        check("fwd_valid", out_valid[p], sv[p]);
      end
    end
  endtask

  task automatic idle_inputs();
    for (int p = 0; p < 2; p++) begin
      in_valid[p]  = 1'b0;
      drain[p]     = 1'b0;
      data_in[p]   = 8'($urandom_range(0, 255));
      weight_in[p] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic check_all_zero(input int p);
    check("rst_data_out", data_out[p], 0);
    check("rst_weight_out", weight_out[p], 0);
    check("rst_out_valid", out_valid[p], 0);
    check("rst_busy", busy[p], 0);
    check("rst_err", err[p], 0);
    check("rst_result", result[p], 0);
    check("rst_res_valid", res_valid[p], 0);
    check("rst_res_sat", res_sat[p], 0);
  endtask

  // Feed the pairs in ta/tb with drain on the last one, optionally poke
  // in_valid during the flush, then check the drained result timing and value.
  task automatic run_tile(input int p, input bit inject);
    longint      sum;
    int          n;
    logic [15:0] exp_res;
    bit          exp_sat;
    n   = ta.size();
    sum = 0;
    for (int i = 0; i < n; i++) sum += longint'(ta[i]) * longint'(tb[i]);
    exp_res = clamp16(sum);
    exp_sat = is_sat16(sum);
    if (n == 0) begin
      drain[p] = 1'b1;
      tick();
    end else begin
      for (int i = 0; i < n; i++) begin
        in_valid[p]  = 1'b1;
        data_in[p]   = ta[i];
        weight_in[p] = tb[i];
        drain[p]     = (i == n - 1);
        tick();
      end
    end
    drain[p]    = 1'b0;
    in_valid[p] = 1'b0;
    check("busy_flush0", busy[p], 1);
    if (inject) begin
      in_valid[p]  = 1'b1;
      data_in[p]   = 8'($urandom_range(1, 127));
      weight_in[p] = 8'($urandom_range(1, 127));
    end
    tick();
    in_valid[p] = 1'b0;
    check("busy_flush1", busy[p], 1);
    if (inject) check("err_set", err[p], 1);
    tick();
    check("busy_flush2", busy[p], 1);
    tick();
    check("busy_done", busy[p], 0);
    check("result", result[p], exp_res);
    check("res_valid", res_valid[p], 1);
    check("res_sat", res_sat[p], exp_sat);
    last_res = exp_res;
    last_sat = exp_sat;
  endtask

  task automatic set_pairs(input int a0, input int b0, input int n);
    ta.delete();
    tb.delete();
    for (int i = 0; i < n; i++) begin
      ta.push_back(8'(a0));
      tb.push_back(8'(b0));
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    repeat (3) tick();
    check_all_zero(0);
    check_all_zero(1);
    reset_n = 1'b1;
    fwd_on  = 1'b1;

    // Forwarding with fixed operands, then flush the accepted pair away.
    in_valid[1] = 1'b1; data_in[1] = 8'h5A; weight_in[1] = 8'h3C;
    tick();
    check("fwd_5a", data_out[1], 8'h5A);
    check("fwd_3c", weight_out[1], 8'h3C);
    idle_inputs();
    do_clear();

    // Basic MAC: 3*4 + 5*6 = 42.
    ta = '{8'sd3, 8'sd5}; tb = '{8'sd4, 8'sd6};
    run_tile(1, 1'b0);

    // Saturation at both ends.
    set_pairs(127, 127, 3);
    run_tile(1, 1'b0);
    set_pairs(-128, 127, 3);
    run_tile(1, 1'b0);

    // Protocol error during flush, then a back-to-back tile.
    set_pairs(2, 3, 1);
    run_tile(1, 1'b1);
    set_pairs(2, 2, 1);
    run_tile(1, 1'b0);
    check("err_sticky", err[1], 1);
    do_clear();
    check("err_cleared", err[1], 0);
    check("clear_keeps_res", result[1], 16'd4);

    // Shift chain: upstream holds 42, downstream 7.
    set_pairs(6, 7, 1);
    run_tile(0, 1'b0);
    set_pairs(7, 1, 1);
    run_tile(1, 1'b0);
    shift_en = 1'b1; up_shift_in = '0; up_shift_valid = 1'b0; up_shift_sat = 1'b0;
    tick();
    check("chain1_dn", result[1], 16'd42);
    check("chain1_dn_v", res_valid[1], 1);
    check("chain1_up_v", res_valid[0], 0);
    check("chain1_up", result[0], 0);
    tick();
    check("chain2_dn", result[1], 0);
    check("chain2_dn_v", res_valid[1], 0);
    shift_en = 1'b0;

    // Clear mid-tile discards the partial sum.
    in_valid[1] = 1'b1; data_in[1] = 8'd9; weight_in[1] = 8'd9;
    tick();
    data_in[1] = 8'd4; weight_in[1] = 8'd4;
    tick();
    in_valid[1] = 1'b0;
    do_clear();
    set_pairs(1, 1, 1);
    run_tile(1, 1'b0);

    // Reset during flush: no result appears.
    in_valid[1] = 1'b1; data_in[1] = 8'd10; weight_in[1] = 8'd10; drain[1] = 1'b1;
    tick();
    idle_inputs();
    tick();
    fwd_on  = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rstmid_busy", busy[1], 0);
    check("rstmid_valid", res_valid[1], 0);
    check("rstmid_result", result[1], 0);
    repeat (2) tick();
    reset_n = 1'b1;
    fwd_on  = 1'b1;
    repeat (4) tick();
    check("rstmid_after_valid", res_valid[1], 0);
    check("rstmid_after_busy", busy[1], 0);

    // Random tiles against the arithmetic model.
    for (int k = 0; k < 40; k++) begin
      int n;
      bit ext;
      ta.delete();
      tb.delete();
      n   = $urandom_range(0, 6);
      ext = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < n; i++) begin
        if (ext) begin
          ta.push_back($urandom_range(0, 1) ? 8'sd127 : -8'sd128);
          tb.push_back($urandom_range(0, 1) ? 8'sd127 : -8'sd128);
        end else begin
          ta.push_back(8'($urandom_range(0, 255)));
          tb.push_back(8'($urandom_range(0, 255)));
        end
      end
      repeat ($urandom_range(0, 2)) begin
        idle_inputs();
        tick();
      end
      run_tile(1, $urandom_range(0, 3) == 0);
      do_clear();
      check("rnd_err_clr", err[1], 0);
      check("rnd_busy_clr", busy[1], 0);
      check("rnd_res_kept", result[1], last_res);
      check("rnd_sat_kept", res_sat[1], last_sat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
